// File: rtl/des_dec_key_sched_if.sv
// des_dec_key_sched_if
// Handshake bundle between the key register, the decryption key schedule and
// the DES round datapath.
//   key_valid/key_in/key_ready          : key load handshake (key_in bit 0 = DES bit 1)
//   subkey_valid/subkey_ready/subkey     : round key stream (subkey bit 0 = PC-2 bit 1)
//   round_idx                            : r-1 of the presented subkey, 15 down to 0
//   subkey_last                          : K1 is being presented
//   done                                 : one-cycle pulse after K1 is accepted
// slave  : view used by the key schedule itself
// master : view used by whoever drives keys and consumes subkeys
interface des_dec_key_sched_if;
  logic        key_valid;
  logic [0:63] key_in;
  logic        key_ready;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [0:47] subkey;
  logic [0:3]  round_idx;
  logic        subkey_last;
  logic        done;

  modport slave (
    input  key_valid, key_in, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, subkey_last, done
  );

  modport master (
    output key_valid, key_in, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, subkey_last, done
  );
endinterface

// File: rtl/des_dec_key_sched.sv
// des_dec_key_sched
// Iterative DES decryption key schedule. Loads one 64-bit key and streams
// K16..K1, one subkey per accepted handshake, using right rotations of C/D.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : des_dec_key_sched_if.slave (key load + subkey stream handshakes)
//
// state | meaning
// IDLE  | waiting for a key, key_ready high
// EMIT  | presenting PC-2(C,D) for round r, rotating on each accept
module des_dec_key_sched (
  input  logic                 clk,
  input  logic                 rst,
  des_dec_key_sched_if.slave   bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  // FIPS 46-3 tables, 1-based bit numbers into key_in and {C,D}.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_q;
  logic [0:27] c_q, d_q;
  logic [4:0]  r_q;
  logic        done_q;

  logic [0:55] pc1_out;
  logic [0:55] cd;
  logic [0:47] pc2_out;
  logic        two_shift;

  // Bit 0 of every vector is DES bit 1, so a table entry n selects index n-1.
  always_comb begin
    pc1_out = '0;
    for (int i = 0; i < 56; i++) pc1_out[i] = bus.key_in[PC1[i] - 1];
  end

  assign cd = {c_q, d_q};

  always_comb begin
    pc2_out = '0;
    for (int i = 0; i < 48; i++) pc2_out[i] = cd[PC2[i] - 1];
  end

  // Shift that took round r-1 to round r in the forward schedule; undoing it
  // steps from K_r back to K_(r-1).
  assign two_shift = !((r_q == 5'd1) || (r_q == 5'd2) ||
                       (r_q == 5'd9) || (r_q == 5'd16));

  function automatic logic [0:27] rotr(input logic [0:27] v, input logic two);
    return two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      r_q     <= 5'd16;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.key_valid) begin
            c_q     <= pc1_out[0:27];
            d_q     <= pc1_out[28:55];
            r_q     <= 5'd16;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (bus.subkey_ready) begin
            if (r_q == 5'd1) begin
              // C/D are left as C1/D1; only the counter is rearmed.
              state_q <= IDLE;
              r_q     <= 5'd16;
              done_q  <= 1'b1;
            end else begin
              c_q <= rotr(c_q, two_shift);
              d_q <= rotr(d_q, two_shift);
              r_q <= r_q - 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.key_ready    = (state_q == IDLE);
  assign bus.subkey_valid = (state_q == EMIT);
  assign bus.subkey       = pc2_out;
  assign bus.round_idx    = 4'(r_q - 5'd1);
  assign bus.subkey_last  = (state_q == EMIT) && (r_q == 5'd1);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
module tb_des_dec_key_sched;

  logic clk;
  logic rst;

  des_dec_key_sched_if bus ();

  des_dec_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  int tests = 0;
  int fails = 0;
  logic [0:47] got [16];

  // Reference: the ordinary forward (encryption) schedule with left rotations,
  // evaluated from scratch for round r.
  function automatic logic [0:47] ref_k(input logic [0:63] key, input int r);
    logic [0:27] c, d;
    logic [0:55] cd;
    logic [0:47] k;
    int sh;
    for (int i = 0; i < 28; i++) begin
      c[i] = key[PC1[i] - 1];
      d[i] = key[PC1[i + 28] - 1];
    end
    for (int rnd = 1; rnd <= r; rnd++) begin
      sh = (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) ? 1 : 2;
      for (int s = 0; s < sh; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[i] = cd[PC2[i] - 1];
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_key_ready"},    64'(bus.key_ready),    64'd1);
    chk({pfx, "_subkey_valid"}, 64'(bus.subkey_valid), 64'd0);
    chk({pfx, "_subkey"},       64'(bus.subkey),       64'd0);
    chk({pfx, "_round_idx"},    64'(bus.round_idx),    64'd15);
    chk({pfx, "_subkey_last"},  64'(bus.subkey_last),  64'd0);
    chk({pfx, "_done"},         64'(bus.done),         64'd0);
  endtask

  // Called at a negedge; the key is taken at the following posedge.
  task automatic start_key(input logic [0:63] key);
    chk("key_ready_before_load", 64'(bus.key_ready), 64'd1);
    bus.key_valid = 1'b1;
    bus.key_in    = key;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Consumes the 16 subkeys with subkey_ready high pct% of cycles. Returns at
  // the negedge right after the K1 accept edge (the done cycle).
  task automatic drain(input logic [0:63] key, input int pct, input bit busy,
                       input logic [0:63] junk, output int ncyc);
    int r = 16;
    int cyc = 0;
    bit rdy;
    while (r >= 1 && cyc < 400) begin
      chk("subkey_valid",  64'(bus.subkey_valid), 64'd1);
      chk("key_ready_busy", 64'(bus.key_ready),   64'd0);
      chk("subkey",        64'(bus.subkey),       64'(ref_k(key, r)));
      chk("round_idx",     64'(bus.round_idx),    64'(r - 1));
      chk("subkey_last",   64'(bus.subkey_last),  64'(r == 1));
      chk("done_low",      64'(bus.done),         64'd0);
      if (busy && cyc == 2) begin
        bus.key_valid = 1'b1;
        bus.key_in    = junk;
      end
      if (busy && cyc == 5) bus.key_valid = 1'b0;
      rdy = ($urandom_range(99) < pct);
      bus.subkey_ready = rdy;
      if (rdy) got[r - 1] = bus.subkey;
      @(negedge clk);
      cyc++;
      if (rdy) r--;
    end
    bus.key_valid = 1'b0;
    if (r >= 1) chk("stream_timeout", 64'(r), 64'd0);
    bus.subkey_ready = 1'($urandom_range(1));
    chk("done_pulse",        64'(bus.done),         64'd1);
    chk("subkey_valid_idle", 64'(bus.subkey_valid), 64'd0);
    chk("key_ready_idle",    64'(bus.key_ready),    64'd1);
    ncyc = cyc;
  endtask

  task automatic done_falls;
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  localparam logic [0:63] KNOWN = 64'h133457799BBCDFF1;

  initial begin
    int n;
    logic [0:63] k, k2;

    rst = 1'b1;
    bus.key_valid    = 1'b0;
    bus.key_in       = '0;
    bus.subkey_ready = 1'b0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // Known vector, no backpressure
    start_key(KNOWN);
    drain(KNOWN, 100, 1'b0, '0, n);
    chk("known_valid_cycles", 64'(n), 64'd16);
    chk("known_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
    chk("known_k15", 64'(got[14]), 64'hBF918D3D3F0A);
    chk("known_k2",  64'(got[1]),  64'h79AED9DBC9E5);
    chk("known_k1",  64'(got[0]),  64'h1B02EFFC7072);
    done_falls();

    // Known vector, random backpressure
    start_key(KNOWN);
    drain(KNOWN, 45, 1'b0, '0, n);
    chk("bp_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
    chk("bp_k1",  64'(got[0]),  64'h1B02EFFC7072);
    done_falls();

    // Degenerate keys
    start_key(64'h0);
    drain(64'h0, 80, 1'b0, '0, n);
    for (int i = 0; i < 16; i++) chk("zero_key", 64'(got[i]), 64'h0);
    done_falls();
    start_key(64'hFFFFFFFFFFFFFFFF);
    drain(64'hFFFFFFFFFFFFFFFF, 100, 1'b0, '0, n);
    for (int i = 0; i < 16; i++) chk("ones_key", 64'(got[i]), 64'hFFFFFFFFFFFF);
    done_falls();
    start_key(64'hFEFEFEFEFEFEFEFE);
    drain(64'hFEFEFEFEFEFEFEFE, 70, 1'b0, '0, n);
    for (int i = 0; i < 16; i++) chk("parity_key", 64'(got[i]), 64'hFFFFFFFFFFFF);
    done_falls();

    // Second key offered while busy must be ignored
    k  = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    start_key(k);
    drain(k, 60, 1'b1, k2, n);
    done_falls();

    // Random keys with random backpressure
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom};
      start_key(k);
      drain(k, 30 + 20 * t, 1'b0, '0, n);
      done_falls();
    end

    // Reset after K12 has been accepted
    start_key(KNOWN);
    bus.subkey_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_round_idx", 64'(bus.round_idx), 64'd10);
    #1 rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    bus.subkey_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_done", 64'(bus.done), 64'd0);
      chk("midreset_ready",   64'(bus.key_ready), 64'd1);
    end
    start_key(KNOWN);
    drain(KNOWN, 100, 1'b0, '0, n);
    chk("after_reset_k16", 64'(got[15]), 64'hCB3D8B0E17F5);
    chk("after_reset_k1",  64'(got[0]),  64'h1B02EFFC7072);

    // Back-to-back: next key accepted in the done cycle
    k = {$urandom, $urandom};
    start_key(k);
    drain(k, 100, 1'b0, '0, n);
    k2 = {$urandom, $urandom};
    start_key(k2);
    drain(k2, 100, 1'b0, '0, n);
    chk("b2b_valid_cycles", 64'(n), 64'd16);
    done_falls();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/des_dec_key_sched.md
# des_dec_key_sched

Iterative DES decryption key schedule: accepts one 64-bit DES key and streams the 16 round subkeys in decryption order (K16 first, K1 last), one per accepted handshake. Right rotations of C/D replace the left rotations of the encryption schedule. Sits between the key register and the DES round datapath when the core runs in decrypt mode, and feeds the same round function that drives the Sbox1–Sbox8 lookups.

## Interface
- No parameters. DES widths are fixed.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  `key_in` is valid.
- `key_in`  in  [0:63]  DES key. Bit 0 is DES bit 1, the MSB. Parity bits 7, 15, …, 63 are ignored.
- `key_ready`  out  1  block is idle and can accept a key.
- `subkey_valid`  out  1  `subkey` holds a valid round key.
- `subkey_ready`  in  1  downstream accepts the current subkey.
- `subkey`  out  [0:47]  round key K_r. Bit 0 is PC-2 output bit 1.
- `round_idx`  out  [0:3]  r−1 for the presented K_r. Counts 15 down to 0.
- `subkey_last`  out  1  high while K1 is presented.
- `done`  out  1  one-cycle pulse after K1 is accepted.

## Operation
- **Registers:**
  - C and D, 28 bits each.
  - round counter r, 5 bits, range 16..1.
  - state: IDLE or EMIT.
  - `done` flop.
- **IDLE:**
  - `key_ready`=1 and `subkey_valid`=0.
  - On `key_valid`&&`key_ready`, load {C,D} = PC-1(`key_in`), set r=16, go to EMIT.
- **EMIT:**
  - `key_ready`=0, `subkey_valid`=1.
  - `subkey` = PC-2(C,D), computed combinationally from the registers.
  - `round_idx` = r−1.
  - `subkey_last` = (r==1).
- **Accept in EMIT** (`subkey_ready`=1):
  - If r>1: rotate C and D right by s_r and decrement r.
  - s_r = 1 for r ∈ {1, 2, 9, 16}; s_r = 2 otherwise.
  - If r==1: go to IDLE and pulse `done` on the next cycle. C and D are left unchanged.
- **Stall in EMIT** (`subkey_ready`=0): hold all state. `subkey` must stay stable.
- **Order is K16 → K1.** K16 = PC-2(C0,D0) because the total encryption rotation is 28. After K2 is accepted, C and D equal C1/D1.
- **Outside IDLE:** `key_valid` is ignored; the key is not queued.
- `subkey_ready` is ignored in IDLE.
- **Permutations:** PC-1 and PC-2 are the FIPS 46-3 tables, pure wiring, no arithmetic.

## Timing
- **Reset (async, immediate):**
  - state=IDLE, C=D=0, r=16.
  - `key_ready`=1, `subkey_valid`=0, `subkey`=0, `round_idx`=15, `subkey_last`=0, `done`=0.
- **Reset mid-stream:** the schedule is abandoned and no `done` is issued. After deassertion, outputs are at reset values and the block accepts a new key.
- **Latency:** key accepted at edge N → K16 valid from just after N. With `subkey_ready` held high, K_r is presented during cycle N+1+(16−r).
- **Throughput:** 16 cycles per key with no backpressure. Earliest next key acceptance is at the edge after `done` rises.
  - IDLE is entered at the edge that accepts K1.
  - `key_ready` is high one cycle before `done` ends, so a key may be accepted in the same cycle `done` is high.
- **Timing of `done`:** high exactly one cycle, in the cycle after K1's accept edge. It is independent of later stalls.
- **Handshake rules:**
  - Once `subkey_valid` rises it stays high until K1 is accepted.
  - `subkey` changes only at accept edges or at reset.

## Test plan
- **Known vector:** key 0x133457799BBCDFF1, `subkey_ready`=1 → stream starts CB3D8B0E17F5 (idx 15), BF918D3D3F0A (idx 14). It ends 79AED9DBC9E5 (idx 1), then 1B02EFFC7072 (idx 0) with `subkey_last`=1. `done` pulses 1 cycle later. Exactly 16 valid cycles.
- **Backpressure:** same key with `subkey_ready` toggled pseudo-randomly → identical 16-key sequence. `subkey` and `round_idx` stay stable during stalls. `done` follows only the K1 accept.
- **Degenerate keys:** key 0x0000000000000000 → all 16 subkeys 0x000000000000. Key 0xFFFFFFFFFFFFFFFF → all FFFFFFFFFFFF. Key 0xFEFEFEFEFEFEFEFE gives the same stream as all-ones, proving parity bits are ignored.
- **Key during busy:** assert `key_valid` with a second key while in EMIT → `key_ready`=0, the second key is ignored, and the first stream completes unchanged.
- **Reset mid-operation:** assert `rst` asynchronously after K12 is accepted → outputs go to reset values immediately and no `done` is issued. Then load 0x133457799BBCDFF1 → full correct stream from CB3D8B0E17F5.
- **Back-to-back keys:** hold `key_valid`=1 with the second key presented while `done` is high → the second key is accepted in the `done` cycle, and its K16 is valid the next cycle with no gap.
